// File: rtl/game_board_ram.sv
// Othello board store: 10x10 array of 2-bit cells with a built-in opening-position loader.
// Define GBR_INIT_ON_RESET_EN to start the opening-position load automatically when reset releases.
module game_board_ram #(
  parameter int BOARD_DIM = 10,
  parameter int ADDR_W    = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic [1:0]        data,
  input  logic              wren,
  output logic [1:0]        q,
  input  logic              init_start,
  output logic              init_busy,
  output logic              init_done
);

  localparam int CELLS = BOARD_DIM * BOARD_DIM;
  localparam int RC_W  = $clog2(BOARD_DIM);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);
  localparam logic [RC_W-1:0]   EDGE_HI   = RC_W'(BOARD_DIM - 1);
  localparam logic [RC_W-1:0]   MID_LO    = RC_W'(BOARD_DIM / 2 - 1);
  localparam logic [RC_W-1:0]   MID_HI    = RC_W'(BOARD_DIM / 2);

  localparam logic [1:0] CELL_EMPTY  = 2'b00;
  localparam logic [1:0] CELL_BLACK  = 2'b01;
  localparam logic [1:0] CELL_WHITE  = 2'b10;
  localparam logic [1:0] CELL_BORDER = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] load_addr;
  logic [RC_W-1:0]   load_row;
  logic [RC_W-1:0]   load_col;
  logic [1:0]        load_cell;
  logic              start_req;
  logic              ext_active;
  logic              load_we;
  logic              in_range;

  logic [1:0] mem [CELLS];

`ifdef GBR_INIT_ON_RESET_EN
  // Behaves like an init_start pulse on the first cycle out of reset.
  logic auto_start;

  always_ff @(posedge clock) begin
    if (reset) auto_start <= 1'b1;
    else       auto_start <= 1'b0;
  end

  assign start_req = init_start | auto_start;
`else
  assign start_req = init_start;
`endif

  assign in_range  = (address <= LAST_ADDR);
  assign init_busy = (state == LOAD);
  assign init_done = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    ext_active = 1'b0;
    load_we    = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        ext_active = 1'b1;
        if (start_req) state_next = LOAD;
      end
      LOAD: begin
        load_we = 1'b1;
        if (load_addr == LAST_ADDR) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Row/column are tracked alongside the linear address to avoid a divider.
  always_ff @(posedge clock) begin
    if (reset || (ext_active && start_req)) begin
      load_addr <= '0;
      load_row  <= '0;
      load_col  <= '0;
    end else if (load_we) begin
      load_addr <= load_addr + 1'b1;
      if (load_col == EDGE_HI) begin
        load_col <= '0;
        load_row <= load_row + 1'b1;
      end else begin
        load_col <= load_col + 1'b1;
      end
    end
  end

  always_comb begin
    load_cell = CELL_EMPTY;
    if (load_row == '0 || load_row == EDGE_HI || load_col == '0 || load_col == EDGE_HI)
      load_cell = CELL_BORDER;
    else if ((load_row == MID_LO && load_col == MID_LO) || (load_row == MID_HI && load_col == MID_HI))
      load_cell = CELL_WHITE;
    else if ((load_row == MID_LO && load_col == MID_HI) || (load_row == MID_HI && load_col == MID_LO))
      load_cell = CELL_BLACK;
  end

  // Array contents survive reset; reset only stops any write in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (load_we)
        mem[load_addr] <= load_cell;
      else if (ext_active && wren && in_range)
        mem[address] <= data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q <= CELL_EMPTY;
    end else if (ext_active) begin
      if (!in_range)
        q <= CELL_BORDER;
      else if (wren)
        q <= data;
      else
        q <= mem[address];
    end
  end

endmodule

// File: tb/tb_game_board_ram.sv
// Self-checking bench for game_board_ram: vector table plus hand-written load/reset/retrigger sequences.
module tb_game_board_ram;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] address;
  logic [1:0] data;
  logic       wren;
  logic [1:0] q;
  logic       init_start;
  logic       init_busy;
  logic       init_done;

  int checks_total  = 0;
  int checks_passed = 0;

  logic [1:0] exp_q [$];

  typedef struct {
    logic [6:0] addr;
    logic [1:0] data;
    logic       wren;
    logic [1:0] exp;
  } vec_t;

  vec_t vecs [$];

  always #5 clock = ~clock;

  game_board_ram #(.BOARD_DIM(10), .ADDR_W(7)) dut (
    .clock      (clock),
    .reset      (reset),
    .address    (address),
    .data       (data),
    .wren       (wren),
    .q          (q),
    .init_start (init_start),
    .init_busy  (init_busy),
    .init_done  (init_done)
  );

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks_total++;
    if (actual === expected) checks_passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  task automatic check_output(input string name);
    logic [1:0] e;
    if (exp_q.size() == 0) begin
      check({name, "_scoreboard_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(name, {30'd0, q}, {30'd0, e});
    end
  endtask

  task automatic apply_stimulus(input logic [6:0] a, input logic [1:0] d, input logic w,
                                input logic [1:0] e, input string name);
    address = a;
    data    = d;
    wren    = w;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    wren = 1'b0;
    check_output(name);
  endtask

  // Counts cycles init_busy is seen high, starting from the sample just after the start edge.
  task automatic run_load(input int retrigger_at, output int n);
    n = 0;
    while (init_busy === 1'b1 && n < 300) begin
      n++;
      init_start = (n == retrigger_at);
      @(posedge clock);
      #1;
    end
    init_start = 1'b0;
  endtask

  task automatic add_vec(input logic [6:0] a, input logic [1:0] d, input logic w, input logic [1:0] e);
    vec_t v;
    v.addr = a;
    v.data = d;
    v.wren = w;
    v.exp  = e;
    vecs.push_back(v);
  endtask

  initial begin
    int n;

    add_vec(7'd0,   2'd0, 1'b0, 2'b11);
    add_vec(7'd9,   2'd0, 1'b0, 2'b11);
    add_vec(7'd90,  2'd0, 1'b0, 2'b11);
    add_vec(7'd99,  2'd0, 1'b0, 2'b11);
    add_vec(7'd44,  2'd0, 1'b0, 2'b10);
    add_vec(7'd45,  2'd0, 1'b0, 2'b01);
    add_vec(7'd54,  2'd0, 1'b0, 2'b01);
    add_vec(7'd55,  2'd0, 1'b0, 2'b10);
    add_vec(7'd33,  2'd0, 1'b0, 2'b00);
    add_vec(7'd19,  2'd0, 1'b0, 2'b11);
    add_vec(7'd80,  2'd0, 1'b0, 2'b11);
    add_vec(7'd81,  2'd0, 1'b0, 2'b00);
    add_vec(7'd98,  2'd0, 1'b0, 2'b11);
    add_vec(7'd34,  2'd1, 1'b1, 2'b01);
    add_vec(7'd34,  2'd0, 1'b0, 2'b01);
    add_vec(7'd120, 2'd1, 1'b1, 2'b11);
    add_vec(7'd120, 2'd0, 1'b0, 2'b11);
    add_vec(7'd100, 2'd0, 1'b0, 2'b11);
    add_vec(7'd127, 2'd0, 1'b0, 2'b11);
    add_vec(7'd99,  2'd0, 1'b1, 2'b00);
    add_vec(7'd99,  2'd0, 1'b0, 2'b00);

    reset      = 1'b1;
    wren       = 1'b0;
    init_start = 1'b0;
    address    = 7'd0;
    data       = 2'd0;
    @(posedge clock);
    #1;
    check("reset_q",    {30'd0, q}, 32'd0);
    check("reset_busy", {31'd0, init_busy}, 32'd0);
    check("reset_done", {31'd0, init_done}, 32'd0);

    reset   = 1'b0;
    address = 7'd120;
`ifdef GBR_INIT_ON_RESET_EN
    init_start = 1'b0;
`else
    init_start = 1'b1;
`endif
    @(posedge clock);
    #1;
    init_start = 1'b0;
    wren       = 1'b1;
    address    = 7'd44;
    data       = 2'd1;
    run_load(0, n);
    wren = 1'b0;
    check("load_cycles",      n, 32'd100);
    check("load_done",        {31'd0, init_done}, 32'd1);
    check("load_busy_after",  {31'd0, init_busy}, 32'd0);
    check("q_held_in_load",   {30'd0, q}, 32'd3);

    for (int i = 0; i < vecs.size(); i++)
      apply_stimulus(vecs[i].addr, vecs[i].data, vecs[i].wren, vecs[i].exp, $sformatf("vec%0d", i));

    address    = 7'd33;
    init_start = 1'b1;
    @(posedge clock);
    #1;
    init_start = 1'b0;
    for (int i = 1; i < 50; i++) begin
      @(posedge clock);
      #1;
    end
    check("busy_at_50", {31'd0, init_busy}, 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", {31'd0, init_busy}, 32'd0);
    check("abort_done", {31'd0, init_done}, 32'd0);
    check("abort_q",    {30'd0, q}, 32'd0);
    reset      = 1'b0;
    init_start = 1'b1;
    @(posedge clock);
    #1;
    init_start = 1'b0;
    run_load(0, n);
    check("reload_cycles", n, 32'd100);
    check("reload_done",   {31'd0, init_done}, 32'd1);
    apply_stimulus(7'd0,  2'd0, 1'b0, 2'b11, "reload_0");
    apply_stimulus(7'd44, 2'd0, 1'b0, 2'b10, "reload_44");
    apply_stimulus(7'd45, 2'd0, 1'b0, 2'b01, "reload_45");
    apply_stimulus(7'd54, 2'd0, 1'b0, 2'b01, "reload_54");
    apply_stimulus(7'd55, 2'd0, 1'b0, 2'b10, "reload_55");
    apply_stimulus(7'd34, 2'd0, 1'b0, 2'b00, "reload_34");
    apply_stimulus(7'd99, 2'd0, 1'b0, 2'b11, "reload_99");

    address    = 7'd33;
    data       = 2'd2;
    wren       = 1'b1;
    init_start = 1'b1;
    exp_q.push_back(2'b10);
    @(posedge clock);
    #1;
    wren       = 1'b0;
    init_start = 1'b0;
    check_output("sim_write_q");
    check("sim_busy", {31'd0, init_busy}, 32'd1);
    check("sim_done", {31'd0, init_done}, 32'd0);
    run_load(30, n);
    check("retrigger_ignored_cycles", n, 32'd100);
    check("retrigger_done", {31'd0, init_done}, 32'd1);
    apply_stimulus(7'd33, 2'd0, 1'b0, 2'b00, "after_sim_33");
    apply_stimulus(7'd44, 2'd0, 1'b0, 2'b10, "after_sim_44");

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
